progress_bar_driver: RTL and testbench
======================================

PROGRESS_BAR_DRIVER -- requirements
Module: progress_bar_driver

Interface
REQ-001 Parameter BAR_WIDTH, default 10, number of LED segments; equals full-scale progress.
REQ-002 Parameter WARN_LEVEL, default 3, highest progress value treated as warning (1..WARN_LEVEL).
REQ-003 clk  input  1  system clock; single clock domain; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; arms the driver for a new round.
REQ-006 tick  input  1  one-cycle blink-rate strobe, synchronous to clk.
REQ-007 progress  input  5  remaining-time value from the countdown block, nominal 0..BAR_WIDTH.
REQ-008 leds  output  BAR_WIDTH  thermometer bar; bit i lit when i < displayed level.
REQ-009 state  output  2  current FSM state code.
REQ-010 timeout  output  1  one-cycle pulse on expiry.
REQ-011 expired  output  1  level; high while in EXPIRED.

Function
REQ-012 FSM states: IDLE=0, RUN=1, WARN=2, EXPIRED=3.
REQ-013 IDLE: leds all 0; start -> RUN; progress ignored.
REQ-014 RUN: progress==0 -> EXPIRED; 1<=progress<=WARN_LEVEL -> WARN; else stay.
REQ-015 WARN: progress==0 -> EXPIRED; progress>WARN_LEVEL -> RUN (countdown reload); else stay.
REQ-016 EXPIRED: hold until start -> RUN; progress changes ignored.
REQ-017 start in any state -> RUN next cycle, clears expired and the blink phase; start has priority over every other transition.
REQ-018 progress > BAR_WIDTH clamped to BAR_WIDTH (full bar); progress is compared only after clamping.
REQ-019 leds registered: 1-cycle latency from progress to leds in RUN/WARN.
REQ-020 EXPIRED: leds all 1 when blink phase=1, all 0 when phase=0 (with BAR_BLINK_EN); all 0 without it.
REQ-021 timeout asserted for exactly one cycle, on the cycle state enters EXPIRED; never re-asserted until a new start.
REQ-022 Entry into EXPIRED is only from RUN or WARN; start and progress==0 in the same cycle -> RUN, no timeout.
REQ-023 Blink phase register toggles on each tick in WARN/EXPIRED; forced to 1 on entry to WARN or EXPIRED and held at 1 elsewhere.

Reset
REQ-024 reset overrides start: state=IDLE, leds=0, timeout=0, expired=0, blink phase=1.
REQ-025 reset mid-round discards any pending transition; no timeout pulse on the reset or following cycle.

Configuration
REQ-026 Macro PROGRESS_BAR_BLINK_EN defined: in WARN, leds = thermometer(progress) when phase=1, all 0 when phase=0; EXPIRED blinks per REQ-020.
REQ-027 Macro undefined: blink phase logic absent; WARN shows a steady thermometer; EXPIRED leds=0; tick unused.

Structure
REQ-028 Shared package progress_pkg holds the state enum/codes, BAR_WIDTH default and WARN_LEVEL default.
REQ-029 Sub-module bar_thermo_enc: combinational clamp plus level-to-thermometer encoder, parameterised by BAR_WIDTH.

Verification
REQ-030 reset, start, progress=10 -> state=RUN; leds=10'h3FF one cycle after progress applied.
REQ-031 progress 10->4->3 -> RUN then WARN on 3; with macro, 2 ticks -> leds 10'h000 then 10'h007.
REQ-032 progress 1->0 in WARN -> timeout high exactly one cycle, expired=1, state=EXPIRED; later progress=5 -> no change.
REQ-033 start and progress=0 in the same cycle from EXPIRED -> state=RUN, expired=0, no timeout.
REQ-034 progress=20 -> leds=10'h3FF, state=RUN; progress=7 -> leds=10'h07F.
REQ-035 reset asserted in WARN with progress=0 -> IDLE, leds=0, timeout stays 0 for all subsequent cycles until start.

Source files
------------

// File: rtl/progress_pkg.sv
// progress_pkg -- shared definitions for the progress bar driver.
//   state_t          : FSM state codes exposed on the driver's state output
//   BAR_WIDTH_DEF    : default number of LED segments (full-scale progress)
//   WARN_LEVEL_DEF   : default highest progress value shown as a warning
package progress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WARN    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int BAR_WIDTH_DEF  = 10;
  localparam int WARN_LEVEL_DEF = 3;

endpackage

// File: rtl/bar_thermo_enc.sv
// bar_thermo_enc -- combinational clamp and level-to-thermometer encoder.
// Ports:
//   progress [4:0]          raw remaining-time value
//   level    [4:0]          progress clamped to BAR_WIDTH
//   thermo   [BAR_WIDTH-1:0] bit i set when i < level
module bar_thermo_enc #(
  parameter int BAR_WIDTH = 10
) (
  input  logic [4:0]           progress,
  output logic [4:0]           level,
  output logic [BAR_WIDTH-1:0] thermo
);

  localparam logic [4:0] BAR_MAX = 5'(BAR_WIDTH);

  // Out-of-range values show a full bar rather than wrapping.
  assign level = (progress > BAR_MAX) ? BAR_MAX : progress;

  genvar gi;
  generate
    for (gi = 0; gi < BAR_WIDTH; gi++) begin : g_seg
      assign thermo[gi] = (level > 5'(gi));
    end
  endgenerate

endmodule

// File: rtl/progress_bar_driver.sv
// progress_bar_driver -- LED progress bar with warning/expiry handling.
// Optional feature macro: PROGRESS_BAR_BLINK_EN (blinking bar in WARN/EXPIRED).
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     one-cycle pulse, (re)arms a round; beats every other transition
//   tick      one-cycle blink-rate strobe (only used with the blink feature)
//   progress  remaining-time value, clamped to BAR_WIDTH before use
//   leds      registered thermometer bar
//   state     current FSM state code (IDLE=0, RUN=1, WARN=2, EXPIRED=3)
//   timeout   one-cycle pulse on the cycle the state becomes EXPIRED
//   expired   high while in EXPIRED
module progress_bar_driver
  import progress_pkg::*;
#(
  parameter int BAR_WIDTH  = BAR_WIDTH_DEF,
  parameter int WARN_LEVEL = WARN_LEVEL_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick,
  input  logic [4:0]           progress,
  output logic [BAR_WIDTH-1:0] leds,
  output logic [1:0]           state,
  output logic                 timeout,
  output logic                 expired
);

  localparam logic [4:0] WARN_MAX = 5'(WARN_LEVEL);

  state_t               state_reg, state_next;
  logic [BAR_WIDTH-1:0] leds_reg, leds_next;
  logic                 timeout_reg, timeout_next;
  logic [4:0]           level;
  logic [BAR_WIDTH-1:0] thermo;

  bar_thermo_enc #(.BAR_WIDTH(BAR_WIDTH)) u_enc (
    .progress (progress),
    .level    (level),
    .thermo   (thermo)
  );

`ifdef PROGRESS_BAR_BLINK_EN
  logic phase_reg, phase_next;
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

  // Next-state and next-output logic. Outputs are computed from the state
  // being entered so the registered leds always agree with the state output.
  always_comb begin
    state_next   = state_reg;
    leds_next    = '0;
    timeout_next = 1'b0;

    if (start) begin
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (level == 5'd0)          state_next = ST_EXPIRED;
          else if (level <= WARN_MAX) state_next = ST_WARN;
        end
        ST_WARN: begin
          if (level == 5'd0)          state_next = ST_EXPIRED;
          else if (level > WARN_MAX)  state_next = ST_RUN;
        end
        default: state_next = state_reg;  // IDLE and EXPIRED wait for start
      endcase
    end

    // Only RUN/WARN can reach EXPIRED, so this fires once per round.
    timeout_next = (state_next == ST_EXPIRED) && (state_reg != ST_EXPIRED);

`ifdef PROGRESS_BAR_BLINK_EN
    phase_next = 1'b1;
    if (!start && (state_next == ST_WARN || state_next == ST_EXPIRED)) begin
      if (state_next != state_reg) phase_next = 1'b1;       // entry
      else if (tick)               phase_next = ~phase_reg;
      else                         phase_next = phase_reg;
    end

    case (state_next)
      ST_RUN:     leds_next = thermo;
      ST_WARN:    leds_next = phase_next ? thermo : '0;
      ST_EXPIRED: leds_next = phase_next ? '1 : '0;
      default:    leds_next = '0;
    endcase
`else
    case (state_next)
      ST_RUN, ST_WARN: leds_next = thermo;
      default:         leds_next = '0;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      leds_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      leds_reg    <= leds_next;
      timeout_reg <= timeout_next;
    end
  end

`ifdef PROGRESS_BAR_BLINK_EN
  always_ff @(posedge clk) begin
    if (reset) phase_reg <= 1'b1;
    else       phase_reg <= phase_next;
  end
`endif

  assign leds    = leds_reg;
  assign state   = state_reg;
  assign timeout = timeout_reg;
  assign expired = (state_reg == ST_EXPIRED);

endmodule

// File: tb/tb_progress_bar_driver.sv
module tb_progress_bar_driver;

  localparam int BW = 10;
  localparam int WL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          tick = 1'b0;
  logic [4:0]    progress = 5'd0;
  logic [BW-1:0] leds;
  logic [1:0]    state;
  logic          timeout;
  logic          expired;

  int tests_run = 0;
  int tests_failed = 0;

  progress_bar_driver #(.BAR_WIDTH(BW), .WARN_LEVEL(WL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tick     (tick),
    .progress (progress),
    .leds     (leds),
    .state    (state),
    .timeout  (timeout),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] leds;
    logic [1:0]    st;
    logic          to;
    logic          ex;
    string         tag;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int m_state = 0;
  bit m_phase = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] therm(input int n);
    logic [BW:0] v;
    v = (11'd1 << n) - 11'd1;
    return v[BW-1:0];
  endfunction

  // Drive one cycle of stimulus, push the model's prediction, then compare
  // the DUT against the popped prediction after the edge.
  task automatic step(input bit rst, input bit st, input bit tk, input int pr, input string tag);
    exp_t e;
    int c, ns;
    bit blink;
    @(negedge clk);
    reset = rst; start = st; tick = tk; progress = 5'(pr);
`ifdef PROGRESS_BAR_BLINK_EN
    blink = 1'b1;
`else
    blink = 1'b0;
`endif
    c = (pr > BW) ? BW : pr;
    e.tag = tag;
    if (rst) begin
      m_state = 0; m_phase = 1'b1;
      e.leds = '0; e.to = 1'b0;
    end else begin
      ns = m_state;
      if (st) ns = 1;
      else if (m_state == 1) begin
        if (c == 0) ns = 3; else if (c <= WL) ns = 2;
      end else if (m_state == 2) begin
        if (c == 0) ns = 3; else if (c > WL) ns = 1;
      end
      e.to = (ns == 3) && (m_state != 3);
      if (st || !(ns == 2 || ns == 3) || ns != m_state) m_phase = 1'b1;
      else if (tk) m_phase = ~m_phase;
      m_state = ns;
      case (ns)
        1: e.leds = therm(c);
        2: e.leds = (!blink || m_phase) ? therm(c) : '0;
        3: e.leds = (blink && m_phase) ? '1 : '0;
        default: e.leds = '0;
      endcase
    end
    e.st = 2'(m_state);
    e.ex = (m_state == 3);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      $display("[TB] %-12s rst=%0b st=%0b tk=%0b pr=%0d -> state=%0d leds=%03h to=%0b ex=%0b",
               e.tag, rst, st, tk, pr, state, leds, timeout, expired);
      check({e.tag, "_leds"},    32'(leds),    32'(e.leds));
      check({e.tag, "_state"},   32'(state),   32'(e.st));
      check({e.tag, "_timeout"}, 32'(timeout), 32'(e.to));
      check({e.tag, "_expired"}, 32'(expired), 32'(e.ex));
    end
  endtask

  initial begin
    // reset, then a start while reset is still high: reset wins
    step(1, 0, 0, 0,  "reset");
    step(1, 1, 0, 10, "reset_start");
    check("rst_state_const", 32'(state), 32'd0);

    // arm, full bar
    step(0, 1, 0, 10, "start");
    step(0, 0, 0, 10, "run10");
    check("run10_leds_const", 32'(leds), 32'h3FF);

    // 10 -> 4 -> 3 enters WARN, then two ticks
    step(0, 0, 0, 4,  "run4");
    step(0, 0, 0, 3,  "warn3");
    check("warn3_state_const", 32'(state), 32'd2);
    step(0, 0, 1, 3,  "warn_tick1");
    step(0, 0, 1, 3,  "warn_tick2");
    check("warn_tick2_leds_const", 32'(leds), 32'h007);

    // expiry: one-cycle timeout, progress ignored afterwards
    step(0, 0, 0, 1,  "warn1");
    step(0, 0, 0, 0,  "expire");
    check("expire_to_const", 32'(timeout), 32'd1);
    step(0, 0, 0, 0,  "exp_hold");
    step(0, 0, 0, 5,  "exp_pr5");
    step(0, 0, 1, 5,  "exp_tick");
    step(0, 0, 1, 9,  "exp_tick2");

    // start with progress=0 from EXPIRED: RUN, no timeout
    step(0, 1, 0, 0,  "restart0");
    check("restart0_ex_const", 32'(expired), 32'd0);

    // clamping
    step(0, 1, 0, 20, "clamp20");
    check("clamp20_leds_const", 32'(leds), 32'h3FF);
    step(0, 0, 0, 31, "clamp31");
    step(0, 0, 0, 7,  "run7");
    check("run7_leds_const", 32'(leds), 32'h07F);

    // WARN -> RUN reload, back to WARN, then reset with progress=0
    step(0, 0, 0, 2,  "warn2");
    step(0, 0, 0, 8,  "reload8");
    step(0, 0, 0, 2,  "warn2b");
    step(1, 0, 0, 0,  "rst_in_warn");
    for (int i = 0; i < 4; i++) step(0, 0, i[0], 0, "idle_after");
    check("idle_to_const", 32'(timeout), 32'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit r, s, t;
      int p;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      step(r, s, t, p, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
